// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline stages.
// Imported by the memory stage and its bus controller.
package mips_pkg;

    localparam int WORD_W          = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } me_state_t;

endpackage

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus controller: IDLE/BUSY FSM, ack timeout counter,
// registered dm_* request signals and the sticky bus-error flag.
import mips_pkg::*;

module mem_bus_ctrl #(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              memRd,
    input  logic              memWr,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wrData,
    input  logic              ack,
    output logic              issue,
    output logic              done,
    output logic              abort,
    output logic              busy,
    output logic              misaligned,
    output logic              stall,
    output logic              busErr,
    output logic [WORD_W-1:0] dmAddr,
    output logic [WORD_W-1:0] dmWrData,
    output logic              dmWr,
    output logic              dmReq
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    me_state_t        state;
    me_state_t        nextState;
    logic [CNT_W-1:0] count;
    logic             memOp;
    logic             aligned;
    logic             atLast;

    assign memOp   = memRd | memWr;
    assign aligned = (addr[1:0] == 2'b00);
    assign atLast  = (count == LAST);
    assign busy    = (state == BUSY);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        issue      = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        misaligned = 1'b0;
        unique case (state)
            IDLE: begin
                misaligned = memOp & ~aligned;
                if (memOp && aligned) begin
                    issue     = 1'b1;
                    nextState = BUSY;
                end
            end
            BUSY: begin
                if (ack) begin
                    done      = 1'b1;
                    nextState = IDLE;
                end else if (atLast) begin
                    abort     = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Reset forces the stall low even while a held memory op sits at the input.
    assign stall = reset & (issue | (busy & ~done & ~abort));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            dmAddr   <= '0;
            dmWrData <= '0;
            dmWr     <= 1'b0;
            dmReq    <= 1'b0;
            busErr   <= 1'b0;
        end else begin
            if (issue) begin
                count    <= '0;
                dmAddr   <= addr;
                dmWrData <= wrData;
                dmWr     <= memWr;
                dmReq    <= 1'b1;
            end else begin
                if (busy && !ack && !atLast) begin
                    count <= count + 1'b1;
                end
                if (done || abort) begin
                    dmReq <= 1'b0;
                end
            end
            if (abort) begin
                busErr <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: drives loads/stores onto the data bus and owns the
// MEM/WB register plus the writeback select mux.
import mips_pkg::*;

module memory_stage #(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ex_MemRd,
    input  logic                  ex_MemWr,
    input  logic [WORD_W-1:0]     ex_ALUOut,
    input  logic [WORD_W-1:0]     ex_OpB_pre,
    input  logic [REG_ADDR_W-1:0] ex_RegDest,
    input  logic                  ex_MemRegSel,
    input  logic                  ex_RegWriteSel,
    output logic [WORD_W-1:0]     dm_Addr,
    output logic [WORD_W-1:0]     dm_WrData,
    output logic                  dm_Wr,
    output logic                  dm_Req,
    input  logic                  dm_Ack,
    input  logic [WORD_W-1:0]     dm_RdData,
    output logic                  me_Stall,
    output logic [WORD_W-1:0]     me_Data,
    output logic [WORD_W-1:0]     wr_Data,
    output logic [REG_ADDR_W-1:0] me_RegDest,
    output logic                  me_RegWriteSel,
    output logic                  me_BusErr,
    output logic                  me_AlignErr
);

    logic issue;
    logic done;
    logic abort;
    logic busy;
    logic misaligned;

    mem_bus_ctrl #(
        .TIMEOUT(TIMEOUT)
    ) u_ctrl (
        .clock     (clock),
        .reset     (reset),
        .memRd     (ex_MemRd),
        .memWr     (ex_MemWr),
        .addr      (ex_ALUOut),
        .wrData    (ex_OpB_pre),
        .ack       (dm_Ack),
        .issue     (issue),
        .done      (done),
        .abort     (abort),
        .busy      (busy),
        .misaligned(misaligned),
        .stall     (me_Stall),
        .busErr    (me_BusErr),
        .dmAddr    (dm_Addr),
        .dmWrData  (dm_WrData),
        .dmWr      (dm_Wr),
        .dmReq     (dm_Req)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            me_Data        <= '0;
            wr_Data        <= '0;
            me_RegDest     <= '0;
            me_RegWriteSel <= 1'b0;
            me_AlignErr    <= 1'b0;
        end else begin
            me_AlignErr <= misaligned;
            if (done) begin
                me_Data        <= dm_Addr;
                wr_Data        <= ex_MemRegSel ? dm_RdData : dm_Addr;
                me_RegDest     <= ex_RegDest;
                me_RegWriteSel <= ex_RegWriteSel;
            end else if (issue || misaligned || abort || busy) begin
                // Bubble: nothing retires through writeback this cycle.
                me_Data        <= '0;
                wr_Data        <= '0;
                me_RegDest     <= '0;
                me_RegWriteSel <= 1'b0;
            end else begin
                me_Data        <= ex_ALUOut;
                wr_Data        <= ex_ALUOut;
                me_RegDest     <= ex_RegDest;
                me_RegWriteSel <= ex_RegWriteSel;
            end
        end
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth stage of the five-stage MIPS pipeline. It consumes the EX/MEM register outputs of the execute stage and runs loads and stores on a word-wide data-memory bus using a req/ack handshake with timeout. It freezes upstream stages while a bus access is outstanding. It drives the MEM/WB register, i.e. the `me_*` / `wr_Data` values the execute stage's forwarding unit reads.

## Interface
- `TIMEOUT`, default 16: maximum number of BUSY cycles to wait for `dm_Ack` before aborting; must be ≥ 2.
- `clock` in 1: sole clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low; asserted (0) clears all state immediately.
- `ex_MemRd` in 1: load request.
- `ex_MemWr` in 1: store request; never asserted together with `ex_MemRd`.
- `ex_ALUOut` in 32: ALU result or effective address.
- `ex_OpB_pre` in 32: store data.
- `ex_RegDest` in 5: destination register.
- `ex_MemRegSel` in 1: 1 selects load data for writeback, 0 selects ALU result.
- `ex_RegWriteSel` in 1: register-file write enable.
- `dm_Addr` out 32: bus word address, registered.
- `dm_WrData` out 32: store data, registered.
- `dm_Wr` out 1: 1 for write, 0 for read; valid while `dm_Req`.
- `dm_Req` out 1: bus request, registered.
- `dm_Ack` in 1: slave completion; read data valid on the same cycle.
- `dm_RdData` in 32: read data.
- `me_Stall` out 1: combinational; freezes the IF/ID/EX registers.
- `me_Data` out 32: registered ALU result (passthrough).
- `wr_Data` out 32: registered writeback value.
- `me_RegDest` out 5: registered destination register.
- `me_RegWriteSel` out 1: registered write enable.
- `me_BusErr` out 1: sticky timeout flag; cleared only by reset.
- `me_AlignErr` out 1: one-cycle pulse on a misaligned access.

## Operation
- FSM has two states: IDLE and BUSY.
- **Reset (0):** every output and register is 0 and the state is IDLE, applied immediately. This holds mid-transaction: `dm_Req` drops at once and the slave must tolerate the abandoned request.
- **IDLE, no memory op:**
  - MEM/WB captures `me_Data`=`ex_ALUOut`, `wr_Data`=`ex_ALUOut`, `me_RegDest`, `me_RegWriteSel`.
  - `me_Stall`=0.
- **IDLE, memory op, `ex_ALUOut[1:0]`≠0 (misaligned):**
  - No bus request.
  - `me_AlignErr` pulses for 1 cycle.
  - MEM/WB captures a bubble (`me_RegWriteSel`=0).
  - `me_Stall`=0.
- **IDLE, aligned memory op:**
  - Registers `dm_Addr`=`ex_ALUOut`, `dm_WrData`=`ex_OpB_pre`, `dm_Wr`=`ex_MemWr`, `dm_Req`=1.
  - Next state is BUSY and the timeout counter is cleared.
  - `me_Stall`=1.
  - MEM/WB captures a bubble.
- **BUSY, `dm_Ack`=1:**
  - `dm_Req` goes to 0 next cycle and the state returns to IDLE.
  - `me_Stall`=0, so upstream advances this cycle.
  - MEM/WB captures `me_Data`=`dm_Addr`, `me_RegDest`, `me_RegWriteSel`.
  - `wr_Data` = `ex_MemRegSel` ? `dm_RdData` : `dm_Addr`.
  - A store writes `me_RegWriteSel` as supplied by upstream (0 for a store).
- **BUSY, no ack, counter < TIMEOUT−1:**
  - Counter increments; `me_Stall`=1; MEM/WB captures a bubble.
  - `dm_Addr`, `dm_WrData`, `dm_Wr` and `dm_Req` hold stable.
- **BUSY, no ack, counter = TIMEOUT−1:**
  - Abort: `dm_Req`→0, state→IDLE, `me_BusErr`→1.
  - `me_Stall`=0 and MEM/WB captures a bubble; the instruction retires without a write.
- Upstream holds all `ex_*` inputs stable while `me_Stall`=1, so decisions made in BUSY use the held `ex_*` values.
- A late `dm_Ack` arriving after an abort, while IDLE, is ignored.

## Timing
- Non-memory op: 1-cycle latency, zero stall.
- Aligned access with ack on the k-th BUSY cycle (k≥1): `me_Stall` is high for k cycles (the IDLE issue cycle plus k−1 BUSY cycles) and the result appears in MEM/WB k+1 edges after issue. The minimum is 2 edges.
- Timeout: exactly TIMEOUT BUSY cycles with `dm_Req`=1, then abort.
- Counter width is $clog2(TIMEOUT); it saturates and never wraps.
- `me_BusErr` rises on the edge that ends the abort cycle.

## Structure
- Shared package `mips_pkg` holds:
  - the `me_state_t` enum (IDLE, BUSY);
  - the `WORD_W`=32 and `REG_ADDR_W`=5 constants;
  - the `TIMEOUT` default.
- Sub-module `mem_bus_ctrl` holds the FSM, timeout counter and `dm_*` registers. It exports `issue`, `done`, `abort` and `busy` to the top level, which owns the MEM/WB registers and the writeback mux.

## Test plan
- **ALU passthrough:** `ex_ALUOut`=0x00001234, `ex_RegWriteSel`=1, `ex_RegDest`=5, no memory op → next edge `wr_Data`=`me_Data`=0x00001234, `me_RegDest`=5, `me_Stall` never 1.
- **Load, ack on 3rd BUSY cycle:** address 0x00000100, `dm_RdData`=0xDEADBEEF, `ex_MemRegSel`=1, `ex_RegDest`=9 →
  - `dm_Req` high for 3 cycles at `dm_Addr`=0x100, `dm_Wr`=0;
  - `me_Stall` high for 3 cycles;
  - bubbles in MEM/WB meanwhile;
  - then `wr_Data`=0xDEADBEEF, `me_RegDest`=9, `me_RegWriteSel`=1.
- **Store, ack on 1st BUSY cycle:** address 0x200, `ex_OpB_pre`=0xCAFEF00D → `dm_Wr`=1, `dm_WrData`=0xCAFEF00D, 1 stall cycle, `me_RegWriteSel`=0.
- **Timeout, TIMEOUT=4, `dm_Ack` held 0:**
  - `dm_Req` high for exactly 4 cycles, then `me_BusErr`=1 and stays 1;
  - `me_Stall` released;
  - a late `dm_Ack` is ignored.
- **Misaligned load at 0x00000102:** `dm_Req` stays 0, `me_AlignErr` is a 1-cycle pulse, `me_RegWriteSel`=0, no stall.
- **Reset mid-access:** drive `reset`=0 during the 2nd BUSY cycle → `dm_Req`, `me_Stall` and all outputs go to 0 without waiting for a clock edge; after release the state is IDLE and a new load completes normally.
